// File: rtl/lcd_hd44780_responder.sv
// Panel-side HD44780 responder: decodes controller bus cycles, holds DDRAM/cursor state,
// models the busy flag and answers status/data reads.
module lcd_hd44780_responder #(
   parameter int unsigned BUSY_CYCLES  = 40,
   parameter int unsigned CLEAR_CYCLES = 1640
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       lcd_rs,
   input  logic       lcd_rw,
   input  logic       lcd_e,
   input  logic [7:0] lcd_data_in,
   output logic [7:0] lcd_data_out,
   output logic       lcd_data_oe,
   output logic       busy,
   output logic [6:0] addr_counter,
   output logic       display_on,
   output logic       wr_valid,
   output logic [6:0] wr_addr,
   output logic [7:0] wr_char,
   output logic       protocol_err,
   input  logic [6:0] dbg_addr,
   output logic [7:0] dbg_char
);

   localparam int unsigned AW      = 7;
   localparam int unsigned DW      = 8;
   localparam int unsigned DEPTH   = 128;
   localparam int unsigned MAX_CYC = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
   localparam int unsigned CW      = $clog2(MAX_CYC + 1);
   localparam logic [DW-1:0] CHAR_SPACE = 8'h20;

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            e_q, e_d;
   logic            rs_lat_q, rs_lat_d;
   logic            rw_lat_q, rw_lat_d;
   logic            seen_rise_q, seen_rise_d;
   logic            mid_chg_q, mid_chg_d;
   logic [AW-1:0]   ac_q, ac_d;
   logic            id_q, id_d;
   logic            s_q, s_d;
   logic            disp_q, disp_d;
   logic            oe_q, oe_d;
   logic [DW-1:0]   dout_q, dout_d;
   logic            wr_valid_q, wr_valid_d;
   logic [AW-1:0]   wr_addr_q, wr_addr_d;
   logic [DW-1:0]   wr_char_q, wr_char_d;
   logic            perr_q, perr_d;
   logic            fill_q, fill_d;
   logic [AW-1:0]   fill_addr_q, fill_addr_d;
   logic [DW-1:0]   ddram_q [DEPTH];

   logic            rise_c, fall_c, is_busy_c;
   logic            busy_start_c, busy_long_c;
   logic            mem_we_c;
   logic [AW-1:0]   mem_waddr_c;
   logic [DW-1:0]   mem_wdata_c;
   logic [DW-1:0]   cmd_c;

   // Cursor step following the two-line DDRAM map; off-map addresses wrap mod 128.
   function automatic logic [AW-1:0] ac_step(input logic [AW-1:0] a, input logic inc);
      logic [AW-1:0] r;
      if (inc) begin
         if (a == 7'h27)      r = 7'h40;
         else if (a == 7'h67) r = 7'h00;
         else                 r = a + AW'(1);
      end else begin
         if (a == 7'h00)      r = 7'h67;
         else if (a == 7'h40) r = 7'h27;
         else                 r = a - AW'(1);
      end
      return r;
   endfunction

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state: busy counter loaded at an accepted write, idle once it reaches zero
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (busy_start_c) begin
               state_d = S_BUSY;
               cnt_d   = busy_long_c ? CW'(CLEAR_CYCLES - 1) : CW'(BUSY_CYCLES - 1);
            end
         end
         S_BUSY: begin
            if (cnt_q == '0) state_d = S_IDLE;
            else             cnt_d   = cnt_q - CW'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output/datapath: strobe decode, reads, command execution, clear fill
   always_comb begin
      rise_c       = lcd_e & ~e_q;
      fall_c       = ~lcd_e & e_q;
      is_busy_c    = (state_q == S_BUSY);
      cmd_c        = lcd_data_in;
      busy_start_c = 1'b0;
      busy_long_c  = 1'b0;
      mem_we_c     = 1'b0;
      mem_waddr_c  = fill_addr_q;
      mem_wdata_c  = CHAR_SPACE;
      e_d          = lcd_e;
      rs_lat_d     = rs_lat_q;
      rw_lat_d     = rw_lat_q;
      seen_rise_d  = seen_rise_q;
      mid_chg_d    = mid_chg_q;
      ac_d         = ac_q;
      id_d         = id_q;
      s_d          = s_q;
      disp_d       = disp_q;
      oe_d         = oe_q;
      dout_d       = dout_q;
      wr_valid_d   = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_char_d    = wr_char_q;
      perr_d       = 1'b0;
      fill_d       = fill_q;
      fill_addr_d  = fill_addr_q;

      if (fill_q) begin
         mem_we_c    = 1'b1;
         fill_addr_d = fill_addr_q + AW'(1);
         if (fill_addr_q == AW'(DEPTH - 1)) fill_d = 1'b0;
      end

      if (rise_c) begin
         rs_lat_d    = lcd_rs;
         rw_lat_d    = lcd_rw;
         seen_rise_d = 1'b1;
         mid_chg_d   = 1'b0;
         if (lcd_rw) begin
            oe_d   = 1'b1;
            dout_d = lcd_rs ? ddram_q[ac_q] : {is_busy_c, ac_q};
         end
      end else if (lcd_e && e_q) begin
         if ((lcd_rs != rs_lat_q) || (lcd_rw != rw_lat_q)) mid_chg_d = 1'b1;
      end

      if (fall_c) begin
         oe_d   = 1'b0;
         dout_d = '0;
      end

      if (fall_c && seen_rise_q) begin
         perr_d = mid_chg_q;
         if (rw_lat_q) begin
            if (rs_lat_q) begin
               if (is_busy_c) perr_d = 1'b1;
               else           ac_d   = ac_step(ac_q, id_q);
            end
         end else if (is_busy_c) begin
            perr_d = 1'b1;
         end else if (rs_lat_q) begin
            mem_we_c     = 1'b1;
            mem_waddr_c  = ac_q;
            mem_wdata_c  = cmd_c;
            wr_valid_d   = 1'b1;
            wr_addr_d    = ac_q;
            wr_char_d    = cmd_c;
            ac_d         = ac_step(ac_q, id_q);
            busy_start_c = 1'b1;
         end else begin
            // Instruction decode keyed on the highest set bit
            busy_start_c = (cmd_c != '0);
            if (cmd_c[7]) begin
               ac_d = cmd_c[6:0];
            end else if (cmd_c[6] || cmd_c[5]) begin
               ac_d = ac_q;
            end else if (cmd_c[4]) begin
               if (!cmd_c[3]) ac_d = ac_step(ac_q, cmd_c[2]);
            end else if (cmd_c[3]) begin
               disp_d = cmd_c[2];
            end else if (cmd_c[2]) begin
               id_d = cmd_c[1];
               s_d  = cmd_c[0];
            end else if (cmd_c[1]) begin
               ac_d        = '0;
               busy_long_c = 1'b1;
            end else if (cmd_c[0]) begin
               ac_d        = '0;
               id_d        = 1'b1;
               fill_d      = 1'b1;
               fill_addr_d = '0;
               busy_long_c = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_q         <= 1'b0;
         rs_lat_q    <= 1'b0;
         rw_lat_q    <= 1'b0;
         seen_rise_q <= 1'b0;
         mid_chg_q   <= 1'b0;
         ac_q        <= '0;
         id_q        <= 1'b1;
         s_q         <= 1'b0;
         disp_q      <= 1'b0;
         oe_q        <= 1'b0;
         dout_q      <= '0;
         wr_valid_q  <= 1'b0;
         wr_addr_q   <= '0;
         wr_char_q   <= '0;
         perr_q      <= 1'b0;
         fill_q      <= 1'b0;
         fill_addr_q <= '0;
      end else begin
         e_q         <= e_d;
         rs_lat_q    <= rs_lat_d;
         rw_lat_q    <= rw_lat_d;
         seen_rise_q <= seen_rise_d;
         mid_chg_q   <= mid_chg_d;
         ac_q        <= ac_d;
         id_q        <= id_d;
         s_q         <= s_d;
         disp_q      <= disp_d;
         oe_q        <= oe_d;
         dout_q      <= dout_d;
         wr_valid_q  <= wr_valid_d;
         wr_addr_q   <= wr_addr_d;
         wr_char_q   <= wr_char_d;
         perr_q      <= perr_d;
         fill_q      <= fill_d;
         fill_addr_q <= fill_addr_d;
      end
   end

   // DDRAM: reset restores the blank-space image
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) ddram_q[i] <= CHAR_SPACE;
      end else if (mem_we_c) begin
         ddram_q[mem_waddr_c] <= mem_wdata_c;
      end
   end

   assign lcd_data_out = dout_q;
   assign lcd_data_oe  = oe_q;
   assign busy         = is_busy_c;
   assign addr_counter = ac_q;
   assign display_on   = disp_q;
   assign wr_valid     = wr_valid_q;
   assign wr_addr      = wr_addr_q;
   assign wr_char      = wr_char_q;
   assign protocol_err = perr_q;
   assign dbg_char     = ddram_q[dbg_addr];

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Directed bench for lcd_hd44780_responder: bus write/read cycles driven and sampled on negedge.
module tb_lcd_hd44780_responder;

   localparam int unsigned BUSY_N  = 40;
   localparam int unsigned CLEAR_N = 1640;
   localparam int          LIMIT   = 4000;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       lcd_rs, lcd_rw, lcd_e;
   logic [7:0] lcd_data_in;
   logic [7:0] lcd_data_out;
   logic       lcd_data_oe, busy, display_on, wr_valid, protocol_err;
   logic [6:0] addr_counter, wr_addr, dbg_addr;
   logic [7:0] wr_char, dbg_char;

   int tests = 0;
   int fails = 0;

   lcd_hd44780_responder #(.BUSY_CYCLES(BUSY_N), .CLEAR_CYCLES(CLEAR_N)) dut (
      .clk(clk), .rst_n(rst_n), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
      .lcd_data_in(lcd_data_in), .lcd_data_out(lcd_data_out), .lcd_data_oe(lcd_data_oe),
      .busy(busy), .addr_counter(addr_counter), .display_on(display_on),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_char(wr_char),
      .protocol_err(protocol_err), .dbg_addr(dbg_addr), .dbg_char(dbg_char)
   );

   always #5 clk = ~clk;

   task automatic bus_write(input logic rs, input logic [7:0] d, output logic v,
                            output logic [6:0] a, output logic [7:0] c, output logic pe);
      @(negedge clk);
      lcd_rs = rs; lcd_rw = 1'b0; lcd_data_in = d; lcd_e = 1'b1;
      @(negedge clk);
      lcd_e = 1'b0;
      @(negedge clk);
      v = wr_valid; a = wr_addr; c = wr_char; pe = protocol_err;
   endtask

   task automatic bus_read(input logic rs, output logic [7:0] val, output logic oe_mid,
                           output logic oe_after, output logic pe);
      @(negedge clk);
      lcd_rs = rs; lcd_rw = 1'b1; lcd_e = 1'b1;
      @(negedge clk);
      val = lcd_data_out; oe_mid = lcd_data_oe; lcd_e = 1'b0;
      @(negedge clk);
      oe_after = lcd_data_oe; pe = protocol_err; lcd_rw = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < LIMIT) begin @(negedge clk); n++; end
      tests++;
      if (busy !== 1'b0) begin fails++; $display("FAIL wait_idle: busy=%b after %0d cycles, need 0", busy, n); end
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (busy && n < LIMIT) begin @(negedge clk); n++; end
   endtask

   task automatic cmd(input logic [7:0] d);
      logic v; logic [6:0] a; logic [7:0] c; logic pe;
      bus_write(1'b0, d, v, a, c, pe);
      wait_idle();
   endtask

   task automatic test_reset();
      logic [7:0] rv; logic om, oa, pe;
      rst_n = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_e = 1'b0; lcd_data_in = '0; dbg_addr = 7'h05;
      repeat (3) @(negedge clk);
      tests++;
      if ({lcd_data_out, lcd_data_oe, busy, addr_counter, display_on, wr_valid, wr_addr, wr_char, protocol_err} !== '0) begin
         fails++; $display("FAIL reset_outputs: out=%h oe=%b busy=%b ac=%h don=%b wv=%b pe=%b, need all 0",
                           lcd_data_out, lcd_data_oe, busy, addr_counter, display_on, wr_valid, protocol_err);
      end
      tests++;
      if (dbg_char !== 8'h20) begin fails++; $display("FAIL reset_ddram: got %h need 20", dbg_char); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      bus_read(1'b0, rv, om, oa, pe);
      tests++;
      if (rv !== 8'h00) begin fails++; $display("FAIL reset_status: got %h need 00", rv); end
      tests++;
      if ({om, oa, busy, pe} !== 4'b1000) begin fails++; $display("FAIL reset_oe: oe_mid=%b oe_after=%b busy=%b pe=%b need 1 0 0 0", om, oa, busy, pe); end
   endtask

   task automatic test_line_wrap();
      logic v, pe; logic [6:0] a; logic [7:0] c;
      cmd(8'hA7);
      tests++;
      if (addr_counter !== 7'h27) begin fails++; $display("FAIL set_ddram_addr: got %h need 27", addr_counter); end
      bus_write(1'b1, 8'h41, v, a, c, pe);
      tests++;
      if ({v, a, c} !== {1'b1, 7'h27, 8'h41}) begin fails++; $display("FAIL wr_A: v=%b a=%h c=%h need 1 27 41", v, a, c); end
      @(negedge clk);
      tests++;
      if (wr_valid !== 1'b0) begin fails++; $display("FAIL wr_pulse: wr_valid=%b one cycle later, need 0", wr_valid); end
      wait_idle();
      bus_write(1'b1, 8'h42, v, a, c, pe);
      tests++;
      if ({v, a, c} !== {1'b1, 7'h40, 8'h42}) begin fails++; $display("FAIL wr_B: v=%b a=%h c=%h need 1 40 42", v, a, c); end
      wait_idle();
      tests++;
      if (addr_counter !== 7'h41) begin fails++; $display("FAIL ac_after_wrap: got %h need 41", addr_counter); end
      dbg_addr = 7'h27; #1;
      tests++;
      if (dbg_char !== 8'h41) begin fails++; $display("FAIL ddram_27: got %h need 41", dbg_char); end
      dbg_addr = 7'h40; #1;
      tests++;
      if (dbg_char !== 8'h42) begin fails++; $display("FAIL ddram_40: got %h need 42", dbg_char); end
   endtask

   task automatic test_busy();
      logic v, pe, om, oa; logic [6:0] a; logic [7:0] c, rv; int n;
      bus_write(1'b1, 8'h43, v, a, c, pe);
      count_busy(n);
      tests++;
      if (n != int'(BUSY_N)) begin fails++; $display("FAIL busy_len: got %0d cycles need %0d", n, BUSY_N); end
      bus_write(1'b1, 8'h44, v, a, c, pe);
      bus_read(1'b0, rv, om, oa, pe);
      tests++;
      if (rv !== 8'hC3) begin fails++; $display("FAIL status_busy: got %h need c3", rv); end
      wait_idle();
      bus_read(1'b0, rv, om, oa, pe);
      tests++;
      if (rv !== 8'h43) begin fails++; $display("FAIL status_idle: got %h need 43", rv); end
   endtask

   task automatic test_write_busy();
      logic v, pe, om, oa; logic [6:0] a; logic [7:0] c, rv;
      bus_write(1'b1, 8'h45, v, a, c, pe);
      tests++;
      if ({v, a, pe} !== {1'b1, 7'h43, 1'b0}) begin fails++; $display("FAIL wr_E: v=%b a=%h pe=%b need 1 43 0", v, a, pe); end
      bus_write(1'b1, 8'h46, v, a, c, pe);
      tests++;
      if ({v, pe} !== 2'b01) begin fails++; $display("FAIL wr_during_busy: v=%b pe=%b need 0 1", v, pe); end
      @(negedge clk);
      tests++;
      if (protocol_err !== 1'b0) begin fails++; $display("FAIL perr_pulse: got %b need 0", protocol_err); end
      bus_write(1'b0, 8'h80, v, a, c, pe);
      tests++;
      if ({pe, addr_counter} !== {1'b1, 7'h44}) begin fails++; $display("FAIL cmd_during_busy: pe=%b ac=%h need 1 44", pe, addr_counter); end
      bus_read(1'b1, rv, om, oa, pe);
      tests++;
      if ({pe, addr_counter} !== {1'b1, 7'h44}) begin fails++; $display("FAIL dread_during_busy: pe=%b ac=%h need 1 44", pe, addr_counter); end
      bus_read(1'b0, rv, om, oa, pe);
      tests++;
      if ({pe, rv} !== {1'b0, 8'hC4}) begin fails++; $display("FAIL sread_during_busy: pe=%b rv=%h need 0 c4", pe, rv); end
      dbg_addr = 7'h44; #1;
      tests++;
      if (dbg_char !== 8'h20) begin fails++; $display("FAIL ddram_44: got %h need 20", dbg_char); end
      wait_idle();
   endtask

   task automatic test_entry_dec();
      logic v, pe, om, oa; logic [6:0] a; logic [7:0] c, rv;
      cmd(8'h04);
      cmd(8'h80);
      bus_write(1'b1, 8'h78, v, a, c, pe);
      tests++;
      if ({v, a, c} !== {1'b1, 7'h00, 8'h78}) begin fails++; $display("FAIL wr_x: v=%b a=%h c=%h need 1 00 78", v, a, c); end
      wait_idle();
      tests++;
      if (addr_counter !== 7'h67) begin fails++; $display("FAIL dec_wrap_00: got %h need 67", addr_counter); end
      cmd(8'h80);
      bus_read(1'b1, rv, om, oa, pe);
      tests++;
      if ({rv, om, oa, pe, addr_counter} !== {8'h78, 1'b1, 1'b0, 1'b0, 7'h67}) begin
         fails++; $display("FAIL dread_00: rv=%h oe=%b%b pe=%b ac=%h need 78 10 0 67", rv, om, oa, pe, addr_counter);
      end
      cmd(8'hC0);
      bus_read(1'b1, rv, om, oa, pe);
      tests++;
      if ({rv, addr_counter} !== {8'h42, 7'h27}) begin fails++; $display("FAIL dread_40: rv=%h ac=%h need 42 27", rv, addr_counter); end
   endtask

   task automatic test_cmds();
      logic v, pe; logic [6:0] a; logic [7:0] c;
      cmd(8'h06);
      cmd(8'h85);
      cmd(8'h14);
      tests++;
      if (addr_counter !== 7'h06) begin fails++; $display("FAIL shift_right: got %h need 06", addr_counter); end
      cmd(8'h10);
      tests++;
      if (addr_counter !== 7'h05) begin fails++; $display("FAIL shift_left: got %h need 05", addr_counter); end
      cmd(8'h1C);
      cmd(8'h38);
      cmd(8'h40);
      tests++;
      if (addr_counter !== 7'h05) begin fails++; $display("FAIL no_ac_change: got %h need 05", addr_counter); end
      cmd(8'h0C);
      tests++;
      if (display_on !== 1'b1) begin fails++; $display("FAIL display_on: got %b need 1", display_on); end
      cmd(8'h08);
      tests++;
      if (display_on !== 1'b0) begin fails++; $display("FAIL display_off: got %b need 0", display_on); end
      bus_write(1'b0, 8'h00, v, a, c, pe);
      tests++;
      if ({busy, pe} !== 2'b00) begin fails++; $display("FAIL noop: busy=%b pe=%b need 0 0", busy, pe); end
      bus_write(1'b0, 8'h38, v, a, c, pe);
      tests++;
      if (busy !== 1'b1) begin fails++; $display("FAIL func_set_busy: got %b need 1", busy); end
      wait_idle();
      cmd(8'hFF);
      bus_write(1'b1, 8'h59, v, a, c, pe);
      wait_idle();
      tests++;
      if ({a, addr_counter} !== {7'h7F, 7'h00}) begin fails++; $display("FAIL inc_7f: wa=%h ac=%h need 7f 00", a, addr_counter); end
      cmd(8'hE7);
      bus_write(1'b1, 8'h47, v, a, c, pe);
      wait_idle();
      tests++;
      if ({a, addr_counter} !== {7'h67, 7'h00}) begin fails++; $display("FAIL inc_67: wa=%h ac=%h need 67 00", a, addr_counter); end
   endtask

   task automatic test_mid_strobe();
      @(negedge clk);
      lcd_rs = 1'b0; lcd_rw = 1'b1; lcd_e = 1'b1;
      @(negedge clk);
      lcd_rw = 1'b0;
      @(negedge clk);
      lcd_e = 1'b0;
      @(negedge clk);
      tests++;
      if ({protocol_err, busy, addr_counter} !== {1'b1, 1'b0, 7'h00}) begin
         fails++; $display("FAIL mid_strobe: pe=%b busy=%b ac=%h need 1 0 00", protocol_err, busy, addr_counter);
      end
      @(negedge clk);
      tests++;
      if (protocol_err !== 1'b0) begin fails++; $display("FAIL mid_strobe_pulse: got %b need 0", protocol_err); end
   endtask

   task automatic test_clear();
      logic v, pe; logic [6:0] a; logic [7:0] c; int n, bad;
      cmd(8'h90);
      bus_write(1'b0, 8'h02, v, a, c, pe);
      count_busy(n);
      tests++;
      if ({n, addr_counter} !== {int'(CLEAR_N), 7'h00}) begin fails++; $display("FAIL home: busy %0d ac=%h need %0d 00", n, addr_counter, CLEAR_N); end
      cmd(8'h04);
      bus_write(1'b0, 8'h01, v, a, c, pe);
      count_busy(n);
      tests++;
      if (n != int'(CLEAR_N)) begin fails++; $display("FAIL clear_busy: got %0d need %0d", n, CLEAR_N); end
      bad = 0;
      for (int i = 0; i < 128; i++) begin
         dbg_addr = 7'(i); #1;
         if (dbg_char !== 8'h20) bad++;
      end
      tests++;
      if (bad != 0) begin fails++; $display("FAIL clear_fill: %0d non-blank cells, need 0", bad); end
      bus_write(1'b1, 8'h48, v, a, c, pe);
      wait_idle();
      tests++;
      if ({a, addr_counter} !== {7'h00, 7'h01}) begin fails++; $display("FAIL clear_id: wa=%h ac=%h need 00 01", a, addr_counter); end
   endtask

   task automatic test_reset_mid();
      logic v, pe; logic [6:0] a; logic [7:0] c; int bad;
      cmd(8'h0C);
      cmd(8'hD0);
      bus_write(1'b1, 8'h5A, v, a, c, pe);
      wait_idle();
      bus_write(1'b0, 8'h01, v, a, c, pe);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      tests++;
      if ({busy, addr_counter, display_on} !== 9'b0) begin fails++; $display("FAIL reset_mid: busy=%b ac=%h don=%b need 0", busy, addr_counter, display_on); end
      rst_n = 1'b1;
      repeat (130) @(negedge clk);
      bad = 0;
      for (int i = 0; i < 128; i++) begin
         dbg_addr = 7'(i); #1;
         if (dbg_char !== 8'h20) bad++;
      end
      tests++;
      if ({busy, bad} !== {1'b0, 32'd0}) begin fails++; $display("FAIL reset_mid_ddram: busy=%b bad=%0d need 0 0", busy, bad); end
   endtask

   initial begin
      test_reset();
      test_line_wrap();
      test_busy();
      test_write_busy();
      test_entry_dec();
      test_cmds();
      test_mid_strobe();
      test_clear();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
